// File: rtl/div_seq_pkg.sv
// Shared encodings for the sequential divider: FSM states, ready/start levels
// and the double-width HI/LO result bus type.
package div_seq_pkg;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;

   typedef logic [63:0] double_reg_bus_t;

endpackage

// File: rtl/div_seq.sv
// Radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle, so the
// EX stage only ever sees a single DW+1-bit subtractor.
module div_seq
   import div_seq_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              signed_div_i,
   input  logic [DW-1:0]     opdata1_i,
   input  logic [DW-1:0]     opdata2_i,
   input  logic              start_i,
   input  logic              annul_i,
   output logic [2*DW-1:0]   result_o,
   output logic              ready_o
);

   localparam int CW = $clog2(DW);

   div_state_e          state_q;
   logic [CW-1:0]       cnt_q;
   logic [2*DW:0]       work_q;
   logic [DW-1:0]       divisor_q;
   logic                signed_q;
   logic                neg1_q;
   logic                neg2_q;
   logic [2*DW-1:0]     result_q;
   logic                ready_q;

   logic [DW-1:0]       abs1;
   logic [DW-1:0]       abs2;
   logic [DW:0]         trial;
   logic [DW-1:0]       quo_fin;
   logic [DW-1:0]       rem_fin;

   // Magnitudes are only taken for signed operands; -2^(DW-1) stays as its own
   // unsigned magnitude, which is what makes the overflow case fall out cleanly.
   assign abs1 = (signed_div_i && opdata1_i[DW-1]) ? -opdata1_i : opdata1_i;
   assign abs2 = (signed_div_i && opdata2_i[DW-1]) ? -opdata2_i : opdata2_i;

   assign trial = work_q[2*DW:DW] - {1'b0, divisor_q};

   // Quotient sign follows the sign mismatch, remainder follows the dividend.
   assign quo_fin = (signed_q && (neg1_q ^ neg2_q)) ? -work_q[DW-1:0] : work_q[DW-1:0];
   assign rem_fin = (signed_q && neg1_q) ? -work_q[2*DW:DW+1] : work_q[2*DW:DW+1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= DivFree;
         cnt_q     <= '0;
         work_q    <= '0;
         divisor_q <= '0;
         signed_q  <= 1'b0;
         neg1_q    <= 1'b0;
         neg2_q    <= 1'b0;
         result_q  <= '0;
         ready_q   <= DivResultNotReady;
      end else begin
         case (state_q)
            DivFree: begin
               ready_q <= DivResultNotReady;
               if (start_i == DivStart && !annul_i) begin
                  if (opdata2_i == '0) begin
                     state_q <= DivByZero;
                  end else begin
                     state_q   <= DivOn;
                     cnt_q     <= '0;
                     signed_q  <= signed_div_i;
                     neg1_q    <= opdata1_i[DW-1];
                     neg2_q    <= opdata2_i[DW-1];
                     divisor_q <= abs2;
                     work_q    <= {{DW{1'b0}}, abs1, 1'b0};
                  end
               end
            end
            DivByZero: begin
               work_q  <= '0;
               state_q <= DivEnd;
            end
            DivOn: begin
               if (annul_i) begin
                  state_q <= DivFree;
               end else begin
                  if (trial[DW]) begin
                     work_q <= {work_q[2*DW-1:0], 1'b0};
                  end else begin
                     work_q <= {trial[DW-1:0], work_q[DW-1:0], 1'b1};
                  end
                  cnt_q <= cnt_q + CW'(1);
                  if (cnt_q == CW'(DW-1)) begin
                     state_q <= DivEnd;
                  end
               end
            end
            DivEnd: begin
               // First END cycle publishes the result; afterwards hold until EX lets go.
               if (ready_q == DivResultNotReady) begin
                  result_q <= {rem_fin, quo_fin};
                  ready_q  <= DivResultReady;
               end else if (start_i == DivStop) begin
                  state_q  <= DivFree;
                  result_q <= '0;
                  ready_q  <= DivResultNotReady;
               end
            end
            default: state_q <= DivFree;
         endcase
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: a latency/arithmetic model checked every cycle,
// plus hand-computed results and latencies for each directed division.
module tb_div_seq;
   import div_seq_pkg::*;

   logic        clk;
   logic        rst;
   logic        signed_div;
   logic [31:0] op1;
   logic [31:0] op2;
   logic        start;
   logic        annul;
   logic [63:0] result_o;
   logic        ready_o;

   int n_cmp = 0;
   int n_bad = 0;
   bit cmp_en = 0;

   div_seq #(.DW(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div),
      .opdata1_i    (op1),
      .opdata2_i    (op2),
      .start_i      (start),
      .annul_i      (annul),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Plain arithmetic reference: {remainder, quotient}, zero for divide by zero.
   function automatic double_reg_bus_t ref_div(input bit sd, input logic [31:0] a, input logic [31:0] b);
      longint na, nb, q, r;
      logic [31:0] qq, rr;
      if (b == 32'd0) return 64'd0;
      if (sd) begin
         na = longint'($signed(a));
         nb = longint'($signed(b));
      end else begin
         na = longint'(a);
         nb = longint'(b);
      end
      q  = na / nb;
      r  = na % nb;
      qq = q[31:0];
      rr = r[31:0];
      return {rr, qq};
   endfunction

   // Timing model: a start accepted at edge T shows ready after T+33 (T+2 for a
   // zero divisor); annul during the iteration window cancels; ready holds until start drops.
   int              m_rem = 0;
   bit              m_zero = 0;
   logic            m_ready = 0;
   double_reg_bus_t m_result = '0;
   double_reg_bus_t m_pending = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_rem    = 0;
         m_ready  = 0;
         m_result = '0;
      end else if (m_ready) begin
         if (!start) begin
            m_ready  = 0;
            m_result = '0;
         end
      end else if (m_rem > 0) begin
         if (!m_zero && m_rem >= 2 && annul) begin
            m_rem = 0;
         end else begin
            m_rem--;
            if (m_rem == 0) begin
               m_ready  = 1;
               m_result = m_pending;
            end
         end
      end else if (start && !annul) begin
         m_zero    = (op2 == 32'd0);
         m_rem     = m_zero ? 2 : 33;
         m_pending = ref_div(signed_div, op1, op2);
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("cyc_ready", {63'd0, ready_o}, {63'd0, m_ready});
         check("cyc_result", result_o, m_result);
      end
   end

   // Called #1 after an edge; the next edge samples the start.
   task automatic run_div(input string name, input bit sd, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_res, input int exp_lat);
      int lat;
      signed_div = sd;
      op1        = a;
      op2        = b;
      start      = 1;
      @(posedge clk);
      #1;
      signed_div = ~sd;
      op1        = $urandom;
      op2        = $urandom;
      lat        = 0;
      while (!ready_o && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!ready_o) begin
         check({name, "_timeout"}, 64'd0, 64'd1);
      end else begin
         check({name, "_latency"}, 64'(lat), 64'(exp_lat));
         check({name, "_result"}, result_o, exp_res);
      end
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      check({name, "_hold"}, result_o, exp_res);
      start = 0;
      @(posedge clk);
      #1;
      check({name, "_release"}, {63'd0, ready_o}, 64'd0);
   endtask

   initial begin
      rst        = 1;
      signed_div = 0;
      op1        = '0;
      op2        = '0;
      start      = 0;
      annul      = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ready", {63'd0, ready_o}, 64'd0);
      check("reset_result", result_o, 64'd0);
      rst    = 0;
      cmp_en = 1;

      run_div("divu_100_7",   0, 32'd100,      32'd7,        {32'd2, 32'd14},                33);
      run_div("div_m7_2",     1, 32'hFFFFFFF9, 32'h00000002, {32'hFFFFFFFF, 32'hFFFFFFFD},  33);
      run_div("div_7_m2",     1, 32'h00000007, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD},  33);
      run_div("div_by_zero",  1, 32'h00001234, 32'h00000000, 64'd0,                         2);
      run_div("divu_max_1",   0, 32'hFFFFFFFF, 32'h00000001, {32'd0, 32'hFFFFFFFF},         33);
      run_div("div_overflow", 1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000},         33);
      run_div("div_min_2",    1, 32'h80000000, 32'h00000002, {32'd0, 32'hC0000000},         33);
      run_div("div_m100_7",   1, 32'hFFFFFF9C, 32'h00000007, {32'hFFFFFFFE, 32'hFFFFFFF2},  33);
      run_div("divu_min_max", 0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'd0},         33);

      // Flush on the 10th iteration cycle, then restart immediately.
      signed_div = 0;
      op1        = 32'd1000;
      op2        = 32'd3;
      start      = 1;
      @(posedge clk);
      repeat (9) @(posedge clk);
      #1;
      annul = 1;
      start = 0;
      @(posedge clk);
      #1;
      annul = 0;
      check("annul_ready", {63'd0, ready_o}, 64'd0);
      run_div("after_annul_50_5", 0, 32'd50, 32'd5, {32'd0, 32'd10}, 33);

      // Reset on the 20th iteration cycle.
      signed_div = 0;
      op1        = 32'd12345;
      op2        = 32'd7;
      start      = 1;
      @(posedge clk);
      repeat (19) @(posedge clk);
      #1;
      rst   = 1;
      start = 0;
      @(posedge clk);
      #1;
      rst = 0;
      check("midrst_ready", {63'd0, ready_o}, 64'd0);
      check("midrst_result", result_o, 64'd0);
      run_div("after_rst_9_3", 0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

      repeat (3) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle 32-bit radix-2 restoring divider with its own sequencing FSM.
- Serves the EX stage for DIV/DIVU. EX asserts start, holds its stall request while the block is busy, and writes result_o to HI/LO through the existing whilo path.
- Replaces a combinational divider so the EX critical path stays one subtractor wide.

Parameters:
- DW, 32, operand width; the iteration count equals DW.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- signed_div_i  in  1  1 = DIV (two's complement), 0 = DIVU
- opdata1_i  in  DW  dividend
- opdata2_i  in  DW  divisor
- start_i  in  1  request from EX; held high until ready_o is seen
- annul_i  in  1  abort the current or pending division (pipeline flush)
- result_o  out  2*DW  {remainder, quotient}; bits [63:32] go to HI, bits [31:0] go to LO
- ready_o  out  1  result_o valid

Behaviour:
- Every output is registered. While rst is high at a clock edge: state = FREE, result_o = 0, ready_o = 0, cnt = 0, work regs = 0.
- States: FREE, BY_ZERO, ON, END. The encodings live in the shared defines.
- FREE, start_i=1, annul_i=0, opdata2_i=0: go to BY_ZERO.
- FREE, start_i=1, annul_i=0, opdata2_i!=0: go to ON with cnt=0.
  - Latch the sign flags and the absolute values of both operands.
  - Absolute values are taken only when signed_div_i=1 and the operand's msb=1.
  - abs(0x80000000) = 0x80000000, treated as unsigned.
  - The working register is {DW'b0, |dividend|, 1'b0}, 2*DW+1 bits.
- FREE, start_i=0 or annul_i=1: stay in FREE; ready_o = 0.
- BY_ZERO: go to END next cycle with work quotient = 0 and work remainder = 0. No annul check is made in this state.
- ON, annul_i=1: go to FREE next cycle. ready_o stays 0 and no result is produced.
- ON, annul_i=0: perform one iteration per cycle.
  - Trial = work[2DW:DW] - {1'b0,|divisor|}.
  - Trial negative: work <= work << 1.
  - Trial non-negative: work <= {trial[DW-1:0], work[DW-1:0], 1'b1}.
  - cnt increments each iteration. On the cycle with cnt = DW-1, the final iteration completes and the state moves to END.
- Entering END: result_o and ready_o load on the same edge.
  - Quotient is work[DW-1:0], negated if signed and the operand signs differ.
  - Remainder is work[2DW:DW+1], negated if signed and the dividend was negative. The remainder takes the dividend's sign.
  - ready_o = 1.
- END: hold result_o and ready_o stable while start_i=1. When start_i=0, go to FREE next cycle with ready_o = 0 and result_o = 0.
- Latency, with start sampled at edge T:
  - Normal division: ON for T+1..T+DW; ready_o = 1 after edge T+DW+1 (33 cycles for DW=32).
  - Divide by zero: ready_o = 1 after edge T+2.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. No trap is raised.
- Operand changes after the start edge are ignored; latched copies are used.
- Reset mid-operation: rst wins over every state, and state returns to FREE on that edge.
- start_i held high after END → FREE does not restart until FREE samples it again. EX must drop start_i when it sees ready_o.

Decomposition:
- defines.v gets:
  - DivFree, DivByZero, DivOn, DivEnd (2-bit encodings)
  - DivResultReady, DivResultNotReady
  - DivStart, DivStop
  - DoubleRegBus [63:0]
- No sub-module. The negate/abs helpers are inline expressions. One file, about 150–200 lines.

Test Plan:
- Unsigned 100 / 7, start at T → ready_o rises after edge T+33, result_o = {32'd2, 32'd14}; stays stable until start_i falls, then ready_o = 0 one cycle later.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also 7 / -2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divisor 0 (opdata1 = 0x1234) → ready_o after edge T+2, result_o = 0. DIVU 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- Annul on the 10th ON cycle → FREE next cycle, ready_o never rises. A new start (50 / 5) the following cycle completes correctly with quotient 10, remainder 0.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Signed 0x80000000 / 2 → quotient 0xC0000000, remainder 0.
- rst pulsed at ON cycle 20 → next edge state FREE, result_o = 0, ready_o = 0. A subsequent 9 / 3 yields quotient 3, remainder 0 on time.
